conj_dot_product_stream: RTL and testbench
==========================================

# conj_dot_product_stream

Parametrised streaming conjugate complex dot-product engine: computes Σ a_k·conj(b_k) over a run-time number of LANES-wide beats, with valid/ready handshakes on input and result, full-precision accumulation and saturating output. It succeeds the fixed eight-element, two-half-beat dot-product unit in the row/vector datapath. Lane count, element width, length and output scaling are all parameters, and the engine carries back-pressure on both ports.

## Interface
- ELEM_W, 64: packed complex element width; real part in upper ELEM_W/2 bits, imag in lower, both signed two's complement (H = ELEM_W/2).
- LANES, 8: complex pairs per beat (power of two, ≥2).
- LEN_W, 16: width of beat-count field.
- FRAC, 0: arithmetic right shift applied to each accumulated component before output saturation (0 ≤ FRAC < 2H).
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all state.
- start  in  1  pulse; accepted only in IDLE.
- len  in  LEN_W  number of beats in the transaction, sampled with start.
- busy  out  1  high in every state except IDLE.
- in_valid  in  1  beat valid.
- in_ready  out  1  engine accepts a beat.
- a_vec  in  ELEM_W*LANES  first operands; lane j at [ELEM_W*(LANES-j)-1 -: ELEM_W].
- b_vec  in  ELEM_W*LANES  second operands (conjugated), same lane layout.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- dot_out  out  ELEM_W  {re, im}, each H bits, saturated.
- sat  out  1  at least one component saturated in this result; valid with out_valid.

## Operation
- Per lane: re = ar·br + ai·bi, im = ai·br − ar·bi (full 2H+1-bit signed).
- Accumulator component width ACC_W = 2H+1+log2(LANES)+LEN_W; no internal overflow possible.
- Output: each component = acc >>> FRAC (arithmetic); if outside [−2^(H−1), 2^(H−1)−1], clamp and set sat.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: in_ready=0, out_valid=0. start=1 → accumulator and pipeline cleared, beat counter := len; len≠0 → RUN; len=0 → DONE with result 0, sat=0.
- RUN: in_ready=1. Beat accepted on in_valid&in_ready; counter decrements. Acceptance of last beat → DRAIN.
- DRAIN: in_ready=0; three-stage pipeline flushes (fixed 3 cycles) → DONE.
- DONE: out_valid=1, dot_out/sat stable until out_ready=1; that edge → IDLE.
- start outside IDLE is ignored; len is not re-sampled.
- in_valid while in_ready=0 is ignored (no beat consumed).
- Reset (any state, including mid-transaction): outputs to reset values, state IDLE, partial sum discarded.

## Timing
- Reset values: busy=0, in_ready=0, out_valid=0, dot_out=0, sat=0.
- Pipeline: stage 1 registered lane products; stage 2 registered lane-sum adder tree; stage 3 accumulator.
- start accepted at edge e → in_ready=1 from cycle after e.
- Last beat accepted at edge k → out_valid=1 after edge k+3; in_ready=0 after edge k.
- Throughput one beat per cycle with no bubbles while in_valid held high.
- out_ready=1 at edge where out_valid=1 → out_valid=0, busy=0 after that edge; next start accepted at the following edge at the earliest.
- len=0: out_valid=1 one cycle after start edge.

## Structure
- Shared package: ELEM_W/H split helpers, ACC_W function, FSM state encoding, saturate-and-shift function.
- One sub-module: conj_cmul_lane (one registered conjugate complex multiply), instantiated LANES times via generate.
- Adder tree, FSM, counter, accumulator and output register live in the top.

## Test plan
- ELEM_W=32, LANES=4, FRAC=0, len=1, lane0 a=1+2j, b=3+4j, others 0 → dot_out={11, 2}, sat=0, out_valid 3 cycles after beat.
- len=4, every lane a=1+1j, b=1−1j, in_valid continuous → per-lane product 0+2j, result {0, 32}; in_ready high exactly 4 cycles.
- len=3 with in_valid toggled 1,0,1,0,1 and out_ready held low 5 cycles → same result as gapless run; dot_out stable while waiting; start during wait ignored.
- len=2, all lanes a=b=32767+0j → re sum 8·32767² clamps to 32767, sat=1; with FRAC=16 → re=8·32767²>>>16=131064, clamps to 32767, sat=1; with FRAC=20 → re=8191, sat=0.
- len=0 → out_valid one cycle after start, dot_out=0, no beat consumed.
- reset=0 asserted mid-RUN after 2 of 5 beats → all outputs 0 immediately; new transaction len=1 (1+2j, 3+4j) yields {11, 2}.

Source files
------------

// File: rtl/conj_dot_product_stream_pkg.sv
// Shared types and helpers for the conjugate dot-product engine:
// FSM encoding, element/accumulator width helpers, shift-and-saturate.
package conj_dot_product_stream_pkg;

   // Widest accumulator any legal parameter set can ask for; the
   // saturation helpers work at this width and callers sign-extend into it.
   localparam int MAX_W = 256;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Width of one real or imaginary half of a packed complex element.
   function automatic int half_w(input int elem_w);
      return elem_w / 2;
   endfunction

   // Accumulator component width: one full-precision lane result (2H+1),
   // plus growth from the lane-sum tree and from up to 2^len_w beats.
   function automatic int acc_width(input int elem_w, input int lanes, input int len_w);
      return elem_w + 1 + $clog2(lanes) + len_w;
   endfunction

   // True when acc >>> frac falls outside the signed h-bit range.
   function automatic logic sat_flag(input logic signed [MAX_W-1:0] acc,
                                     input int frac, input int h);
      logic signed [MAX_W-1:0] shifted;
      logic signed [MAX_W-1:0] max_v;
      logic signed [MAX_W-1:0] min_v;
      shifted = acc >>> frac;
      max_v   = (MAX_W'(1) << (h - 1)) - MAX_W'(1);
      min_v   = ~max_v;
      return (shifted > max_v) || (shifted < min_v);
   endfunction

   // acc >>> frac clamped to the signed h-bit range, sign-extended to MAX_W.
   function automatic logic [MAX_W-1:0] sat_value(input logic signed [MAX_W-1:0] acc,
                                                  input int frac, input int h);
      logic signed [MAX_W-1:0] shifted;
      logic signed [MAX_W-1:0] max_v;
      logic signed [MAX_W-1:0] min_v;
      shifted = acc >>> frac;
      max_v   = (MAX_W'(1) << (h - 1)) - MAX_W'(1);
      min_v   = ~max_v;
      if (shifted > max_v)      return max_v;
      else if (shifted < min_v) return min_v;
      else                      return shifted;
   endfunction

endpackage

// File: rtl/conj_dot_product_stream_cmul.sv
// One lane: registered conjugate complex multiply a * conj(b) at full
// precision (2H+1 bits per component, so no rounding or wrap is possible).
module conj_cmul_lane
   import conj_dot_product_stream_pkg::*;
#(
   parameter int H = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [2*H-1:0]       a,
   input  logic [2*H-1:0]       b,
   output logic signed [2*H:0]  prod_re,
   output logic signed [2*H:0]  prod_im
);

   localparam int P = 2 * H;
   localparam int W = 2 * H + 1;

   logic signed [H-1:0] ar, ai, br, bi;
   logic signed [P-1:0] p_rr, p_ii, p_ir, p_ri;
   logic signed [W-1:0] re_c, im_c;

   assign ar = a[P-1 -: H];
   assign ai = a[H-1:0];
   assign br = b[P-1 -: H];
   assign bi = b[H-1:0];

   // Partial products widened before multiplying; re = ar*br + ai*bi, im = ai*br - ar*bi.
   always_comb begin
      p_rr = P'(ar) * P'(br);
      p_ii = P'(ai) * P'(bi);
      p_ir = P'(ai) * P'(br);
      p_ri = P'(ar) * P'(bi);
      re_c = W'(p_rr) + W'(p_ii);
      im_c = W'(p_ir) - W'(p_ri);
   end

   // Stage-1 product register; free-running, qualified by the valid pipe in the top.
   // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prod_re <= '0;
         prod_im <= '0;
      end else begin
         prod_re <= re_c;
         prod_im <= im_c;
      end
   end

endmodule

// File: rtl/conj_dot_product_stream.sv
// Streaming conjugate complex dot product: sum of a_k * conj(b_k) over
// len beats of LANES pairs, three-stage pipeline, saturating output.
module conj_dot_product_stream
   import conj_dot_product_stream_pkg::*;
#(
   parameter int ELEM_W = 64,
   parameter int LANES  = 8,
   parameter int LEN_W  = 16,
   parameter int FRAC   = 0
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic [LEN_W-1:0]          len,
   output logic                      busy,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [ELEM_W*LANES-1:0]   a_vec,
   input  logic [ELEM_W*LANES-1:0]   b_vec,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [ELEM_W-1:0]         dot_out,
   output logic                      sat
);

   localparam int H      = half_w(ELEM_W);
   localparam int PROD_W = ELEM_W + 1;
   localparam int SUM_W  = PROD_W + $clog2(LANES);
   localparam int ACC_W  = acc_width(ELEM_W, LANES, LEN_W);

   state_t                    state_q, state_d;
   logic [LEN_W-1:0]          beat_cnt_q;
   logic [1:0]                drain_cnt_q;
   logic                      start_accept, beat_accept, load_zero, load_result;
   logic                      v1_q, v2_q;
   logic signed [PROD_W-1:0]  lane_re [LANES];
   logic signed [PROD_W-1:0]  lane_im [LANES];
   logic signed [SUM_W-1:0]   sum_re_c, sum_im_c, sum_re_q, sum_im_q;
   logic signed [ACC_W-1:0]   acc_re_q, acc_im_q;
   logic [H-1:0]              re_sat, im_sat;
   logic                      re_flag, im_flag;

   for (genvar j = 0; j < LANES; j++) begin : g_lane
      conj_cmul_lane #(.H(H)) u_lane (
         .clk     (clk),
         .reset   (reset),
         .a       (a_vec[ELEM_W*(LANES-j)-1 -: ELEM_W]),
         .b       (b_vec[ELEM_W*(LANES-j)-1 -: ELEM_W]),
         .prod_re (lane_re[j]),
         .prod_im (lane_im[j])
      );
   end

   // Lane-sum tree over the stage-1 products.
   always_comb begin
      sum_re_c = '0;
      sum_im_c = '0;
      for (int j = 0; j < LANES; j++) begin
         sum_re_c = sum_re_c + SUM_W'(lane_re[j]);
         sum_im_c = sum_im_c + SUM_W'(lane_im[j]);
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic and handshake outputs.
   // NOTE: every output of this block gets a default first so no path infers a latch.
   always_comb begin
      state_d      = state_q;
      busy         = 1'b1;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      start_accept = 1'b0;
      beat_accept  = 1'b0;
      load_zero    = 1'b0;
      load_result  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            busy = 1'b0;
            if (start) begin
               start_accept = 1'b1;
               if (len == '0) begin
                  load_zero = 1'b1;
                  state_d   = ST_DONE;
               end else begin
                  state_d   = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            in_ready = 1'b1;
            if (in_valid) begin
               beat_accept = 1'b1;
               if (beat_cnt_q == LEN_W'(1)) state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (drain_cnt_q == 2'd2) begin
               load_result = 1'b1;
               state_d     = ST_DONE;
            end
         end
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Remaining-beat counter and fixed three-cycle drain counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         beat_cnt_q  <= '0;
         drain_cnt_q <= '0;
      end else begin
         if (start_accept)     beat_cnt_q <= len;
         else if (beat_accept) beat_cnt_q <= beat_cnt_q - LEN_W'(1);
         if (state_q == ST_DRAIN) drain_cnt_q <= drain_cnt_q + 2'd1;
         else                     drain_cnt_q <= '0;
      end
   end

   // Stage-2 sum register, valid pipe and stage-3 accumulator.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         v1_q     <= 1'b0;
         v2_q     <= 1'b0;
         sum_re_q <= '0;
         sum_im_q <= '0;
         acc_re_q <= '0;
         acc_im_q <= '0;
      end else begin
         sum_re_q <= sum_re_c;
         sum_im_q <= sum_im_c;
         if (start_accept) begin
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            acc_re_q <= '0;
            acc_im_q <= '0;
         end else begin
            v1_q <= beat_accept;
            v2_q <= v1_q;
            if (v2_q) begin
               acc_re_q <= acc_re_q + ACC_W'(sum_re_q);
               acc_im_q <= acc_im_q + ACC_W'(sum_im_q);
            end
         end
      end
   end

   // Scale and clamp each accumulated component to H bits.
   always_comb begin
      re_sat  = H'(sat_value(MAX_W'(acc_re_q), FRAC, H));
      im_sat  = H'(sat_value(MAX_W'(acc_im_q), FRAC, H));
      re_flag = sat_flag(MAX_W'(acc_re_q), FRAC, H);
      im_flag = sat_flag(MAX_W'(acc_im_q), FRAC, H);
   end

   // Output register: loaded once per transaction, held through DONE.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dot_out <= '0;
         sat     <= 1'b0;
      end else if (load_zero) begin
         dot_out <= '0;
         sat     <= 1'b0;
      end else if (load_result) begin
         dot_out <= {re_sat, im_sat};
         sat     <= re_flag | im_flag;
      end
   end

endmodule

// File: tb/tb_conj_dot_product_stream.sv
// Self-checking bench: three engines (FRAC 0/16/20) driven in lockstep from
// a vector table; expected results queued at start, compared at out_valid.
`timescale 1ns/1ps
module tb_conj_dot_product_stream;

   localparam int ELEM_W = 32;
   localparam int LANES  = 4;
   localparam int LEN_W  = 16;
   localparam int VW     = ELEM_W * LANES;
   localparam int NV     = 7;

   typedef struct {
      int             len;
      logic [VW-1:0]  a;
      logic [VW-1:0]  b;
      bit             gappy;
      int             hold;
      logic [31:0]    exp_dot;
      logic           exp_sat;
   } vec_t;

   typedef struct packed {
      logic [2:0][31:0] dot;
      logic [2:0]       sat;
   } exp_t;

   logic              clk = 1'b0;
   logic              reset, start, in_valid, out_ready;
   logic [LEN_W-1:0]  len;
   logic [VW-1:0]     a_vec, b_vec;
   logic              busy_w [3];
   logic              in_ready_w [3];
   logic              out_valid_w [3];
   logic              sat_w [3];
   logic [ELEM_W-1:0] dot_w [3];

   int   n_checks = 0;
   int   n_pass   = 0;
   exp_t sb[$];
   vec_t vecs [NV];

   always #5 clk = ~clk;

   conj_dot_product_stream #(.ELEM_W(ELEM_W), .LANES(LANES), .LEN_W(LEN_W), .FRAC(0)) dut0 (
      .clk(clk), .reset(reset), .start(start), .len(len), .busy(busy_w[0]),
      .in_valid(in_valid), .in_ready(in_ready_w[0]), .a_vec(a_vec), .b_vec(b_vec),
      .out_valid(out_valid_w[0]), .out_ready(out_ready), .dot_out(dot_w[0]), .sat(sat_w[0]));

   conj_dot_product_stream #(.ELEM_W(ELEM_W), .LANES(LANES), .LEN_W(LEN_W), .FRAC(16)) dut16 (
      .clk(clk), .reset(reset), .start(start), .len(len), .busy(busy_w[1]),
      .in_valid(in_valid), .in_ready(in_ready_w[1]), .a_vec(a_vec), .b_vec(b_vec),
      .out_valid(out_valid_w[1]), .out_ready(out_ready), .dot_out(dot_w[1]), .sat(sat_w[1]));

   conj_dot_product_stream #(.ELEM_W(ELEM_W), .LANES(LANES), .LEN_W(LEN_W), .FRAC(20)) dut20 (
      .clk(clk), .reset(reset), .start(start), .len(len), .busy(busy_w[2]),
      .in_valid(in_valid), .in_ready(in_ready_w[2]), .a_vec(a_vec), .b_vec(b_vec),
      .out_valid(out_valid_w[2]), .out_ready(out_ready), .dot_out(dot_w[2]), .sat(sat_w[2]));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Exact per-beat sums of a*conj(b) over all lanes.
   function automatic void beat_sum(input logic [VW-1:0] a, input logic [VW-1:0] b,
                                    output longint re, output longint im);
      logic [31:0] ea, eb;
      longint ar, ai, br, bi;
      re = 0;
      im = 0;
      for (int j = 0; j < LANES; j++) begin
         ea = a[ELEM_W*(LANES-j)-1 -: ELEM_W];
         eb = b[ELEM_W*(LANES-j)-1 -: ELEM_W];
         ar = longint'(signed'(ea[31:16]));
         ai = longint'(signed'(ea[15:0]));
         br = longint'(signed'(eb[31:16]));
         bi = longint'(signed'(eb[15:0]));
         re = re + ar * br + ai * bi;
         im = im + ai * br - ar * bi;
      end
   endfunction

   function automatic logic [16:0] sat16(input longint v, input int frac);
      longint s;
      s = v >>> frac;
      if (s > 32767)  return 17'h1_7FFF;
      if (s < -32768) return 17'h1_8000;
      return {1'b0, s[15:0]};
   endfunction

   function automatic logic [32:0] model_out(input longint re, input longint im, input int frac);
      logic [16:0] r, i;
      r = sat16(re, frac);
      i = sat16(im, frac);
      return {r[16] | i[16], r[15:0], i[15:0]};
   endfunction

   task automatic run_vec(input vec_t v);
      longint      bre, bim;
      exp_t        e;
      logic [32:0] m;
      logic [31:0] held;
      int          ready_cycles, accepted, cyc, lat;

      beat_sum(v.a, v.b, bre, bim);
      bre = bre * v.len;
      bim = bim * v.len;
      e.dot[0] = v.exp_dot;
      e.sat[0] = v.exp_sat;
      m = model_out(bre, bim, 16);
      e.sat[1] = m[32];
      e.dot[1] = m[31:0];
      m = model_out(bre, bim, 20);
      e.sat[2] = m[32];
      e.dot[2] = m[31:0];
      sb.push_back(e);

      start    = 1'b1;
      len      = LEN_W'(v.len);
      in_valid = (v.len == 0);
      a_vec    = v.a;
      b_vec    = v.b;
      tick();
      start = 1'b0;

      if (v.len == 0) begin
         check("len0_out_valid", 64'(out_valid_w[0]), 64'd1);
         check("len0_in_ready", 64'(in_ready_w[0]), 64'd0);
      end else begin
         check("ready_after_start", 64'(in_ready_w[0]), 64'd1);
         ready_cycles = 0;
         accepted     = 0;
         cyc          = 0;
         while (accepted < v.len && cyc < 64) begin
            in_valid = v.gappy ? (cyc % 2 == 0) : 1'b1;
            if (in_ready_w[0]) ready_cycles++;
            if (in_valid && in_ready_w[0]) accepted++;
            tick();
            cyc++;
         end
         // Keep offering junk while draining; it must not be consumed.
         in_valid = 1'b1;
         a_vec    = '1;
         b_vec    = '1;
         check("ready_drop", 64'(in_ready_w[0]), 64'd0);
         check("ready_cycles", 64'(ready_cycles), 64'(v.gappy ? 2 * v.len - 1 : v.len));
         lat = 0;
         while (!out_valid_w[0] && lat < 20) begin
            tick();
            lat++;
         end
         check("latency", 64'(lat), 64'd3);
      end
      in_valid  = 1'b0;

      held      = dot_w[0];
      out_ready = 1'b0;
      for (int i = 0; i < v.hold; i++) begin
         start = (i == 1);
         len   = LEN_W'(7);
         tick();
         start = 1'b0;
         check("hold_valid", 64'(out_valid_w[0]), 64'd1);
         check("hold_stable", 64'(dot_w[0]), 64'(held));
      end

      check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         for (int k = 0; k < 3; k++) begin
            check($sformatf("out_valid[%0d]", k), 64'(out_valid_w[k]), 64'd1);
            check($sformatf("dot_out[%0d]", k), 64'(dot_w[k]), 64'(e.dot[k]));
            check($sformatf("sat[%0d]", k), 64'(sat_w[k]), 64'(e.sat[k]));
         end
      end

      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         check($sformatf("release_valid[%0d]", k), 64'(out_valid_w[k]), 64'd0);
         check($sformatf("release_busy[%0d]", k), 64'(busy_w[k]), 64'd0);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      for (int k = 0; k < 3; k++) begin
         check($sformatf("%s_busy[%0d]", tag, k), 64'(busy_w[k]), 64'd0);
         check($sformatf("%s_in_ready[%0d]", tag, k), 64'(in_ready_w[k]), 64'd0);
         check($sformatf("%s_out_valid[%0d]", tag, k), 64'(out_valid_w[k]), 64'd0);
         check($sformatf("%s_dot[%0d]", tag, k), 64'(dot_w[k]), 64'd0);
         check($sformatf("%s_sat[%0d]", tag, k), 64'(sat_w[k]), 64'd0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // len, a, b, gappy, hold, expected dot (FRAC=0), expected sat
      vecs[0] = '{1, {32'h0001_0002, 96'h0}, {32'h0003_0004, 96'h0}, 1'b0, 1, 32'h000B_0002, 1'b0};
      vecs[1] = '{4, {4{32'h0001_0001}}, {4{32'h0001_FFFF}}, 1'b0, 1, 32'h0000_0020, 1'b0};
      vecs[2] = '{3, {4{32'h0001_0001}}, {4{32'h0001_FFFF}}, 1'b1, 5, 32'h0000_0018, 1'b0};
      vecs[3] = '{2, {4{32'h7FFF_0000}}, {4{32'h7FFF_0000}}, 1'b0, 2, 32'h7FFF_0000, 1'b1};
      vecs[4] = '{0, {4{32'h1234_5678}}, {4{32'h0101_0101}}, 1'b0, 1, 32'h0000_0000, 1'b0};
      vecs[5] = '{1, {4{32'h8000_0000}}, {4{32'h7FFF_0000}}, 1'b0, 1, 32'h8000_0000, 1'b1};
      vecs[6] = '{2, {32'hFFFD_0005, 32'h0007_FFFE, 64'h0},
                     {32'h0002_FFFF, 32'hFFFC_0006, 64'h0}, 1'b0, 1, 32'hFF9A_FFCA, 1'b0};

      reset     = 1'b0;
      start     = 1'b0;
      len       = '0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a_vec     = '0;
      b_vec     = '0;
      @(negedge clk);
      @(negedge clk);
      check_reset_outputs("por");
      reset = 1'b1;
      tick();

      for (int i = 0; i < NV; i++) run_vec(vecs[i]);

      // Reset mid-transaction: 2 of 5 beats in, then abort and rerun.
      start = 1'b1;
      len   = LEN_W'(5);
      tick();
      start    = 1'b0;
      in_valid = 1'b1;
      a_vec    = vecs[0].a;
      b_vec    = vecs[0].b;
      tick();
      tick();
      check("mid_run_ready", 64'(in_ready_w[0]), 64'd1);
      reset = 1'b0;
      #1;
      check_reset_outputs("mid");
      in_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      tick();
      run_vec(vecs[0]);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
